// File: rtl/input_debouncer.sv
// Per-channel synchronizer + debounce FSM for raw switches/buttons.
// Produces a clean level per channel and registered single-cycle rise/fall pulses.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// STABLE_LOW  | accepted level 0, watching for s=1
// WAIT_HIGH   | s went high, counting consecutive high cycles in cnt
// STABLE_HIGH | accepted level 1, watching for s=0
// WAIT_LOW    | s went low, counting consecutive low cycles in cnt
module input_debouncer #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  state_t           state  [WIDTH];
  logic [CW-1:0]    cnt    [WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Pulses are set on the same edge that flips level_out, so each lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= STABLE_LOW;
        cnt[i]   <= '0;
      end
      level_out  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        case (state[i])
          STABLE_LOW: begin
            if (s[i]) begin
              state[i] <= WAIT_HIGH;
              cnt[i]   <= CW'(1);
            end
          end
          WAIT_HIGH: begin
            if (!s[i]) begin
              state[i] <= STABLE_LOW;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_TOP) begin
              state[i]      <= STABLE_HIGH;
              cnt[i]        <= '0;
              level_out[i]  <= 1'b1;
              rise_pulse[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          STABLE_HIGH: begin
            if (!s[i]) begin
              state[i] <= WAIT_LOW;
              cnt[i]   <= CW'(1);
            end
          end
          WAIT_LOW: begin
            if (s[i]) begin
              state[i] <= STABLE_HIGH;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_TOP) begin
              state[i]      <= STABLE_LOW;
              cnt[i]        <= '0;
              level_out[i]  <= 1'b0;
              fall_pulse[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: begin
            state[i] <= STABLE_LOW;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with WIDTH=2, SYNC_STAGES=2, CNT_MAX=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_input_debouncer;

  logic       clk;
  logic       rst_n;
  logic [1:0] raw_in;
  logic [1:0] level_out;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;

  int errors;
  int checks;

  logic [1:0] exp_lvl;
  logic [1:0] exp_rise;
  logic [1:0] exp_fall;
  logic       exp_x;
  int         n_rise0, n_rise1, n_fall0, n_fall1;

  input_debouncer #(
    .WIDTH      (2),
    .SYNC_STAGES(2),
    .CNT_MAX    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    raw_in = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({level_out, rise_pulse, fall_pulse} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got lvl=%b rise=%b fall=%b exp all 0", i, level_out, rise_pulse, fall_pulse);
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_lvl  = (i >= 7) ? 2'b11 : 2'b00;
      exp_rise = (i == 7) ? 2'b11 : 2'b00;
      checks++;
      if (level_out !== exp_lvl || rise_pulse !== exp_rise || fall_pulse !== 2'b00) begin
        errors++;
        $display("FAIL reset_release step=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=00",
                 i, level_out, rise_pulse, fall_pulse, exp_lvl, exp_rise);
      end
    end
    raw_in = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_lvl  = (i >= 7) ? 2'b00 : 2'b11;
      exp_fall = (i == 7) ? 2'b11 : 2'b00;
      checks++;
      if (level_out !== exp_lvl || fall_pulse !== exp_fall || rise_pulse !== 2'b00) begin
        errors++;
        $display("FAIL reset_both_fall step=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=00 fall=%b",
                 i, level_out, rise_pulse, fall_pulse, exp_lvl, exp_fall);
      end
    end
  endtask

  task automatic test_clean_press();
    raw_in = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_lvl  = (i >= 7) ? 2'b01 : 2'b00;
      exp_rise = (i == 7) ? 2'b01 : 2'b00;
      exp_x    = (i >= 7);
      checks++;
      if (level_out !== exp_lvl || rise_pulse !== exp_rise || fall_pulse !== 2'b00 ||
          (level_out[0] ^ level_out[1]) !== exp_x) begin
        errors++;
        $display("FAIL press step=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=00 xor=%b",
                 i, level_out, rise_pulse, fall_pulse, exp_lvl, exp_rise, exp_x);
      end
    end
    raw_in = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_lvl  = (i >= 7) ? 2'b00 : 2'b01;
      exp_fall = (i == 7) ? 2'b01 : 2'b00;
      checks++;
      if (level_out !== exp_lvl || fall_pulse !== exp_fall || rise_pulse !== 2'b00) begin
        errors++;
        $display("FAIL release step=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=00 fall=%b",
                 i, level_out, rise_pulse, fall_pulse, exp_lvl, exp_fall);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 18; i++) begin
      raw_in = (i < 8) ? {1'b0, ~i[1]} : 2'b00;
      step();
      checks++;
      if (level_out !== 2'b00 || rise_pulse !== 2'b00 || fall_pulse !== 2'b00) begin
        errors++;
        $display("FAIL bounce cyc=%0d got lvl=%b rise=%b fall=%b exp all 00", i, level_out, rise_pulse, fall_pulse);
      end
    end
    // 4 stable high cycles at s: one short of acceptance
    raw_in = 2'b01;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 4) raw_in = 2'b00;
      checks++;
      if (level_out !== 2'b00 || rise_pulse !== 2'b00 || fall_pulse !== 2'b00) begin
        errors++;
        $display("FAIL glitch4 step=%0d got lvl=%b rise=%b fall=%b exp all 00", i, level_out, rise_pulse, fall_pulse);
      end
    end
    // 5 stable high cycles: accepted at edge 6, then 5 low cycles drop it at edge 11
    raw_in = 2'b01;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (i == 5) raw_in = 2'b00;
      exp_lvl  = (i >= 7 && i <= 11) ? 2'b01 : 2'b00;
      exp_rise = (i == 7)  ? 2'b01 : 2'b00;
      exp_fall = (i == 12) ? 2'b01 : 2'b00;
      checks++;
      if (level_out !== exp_lvl || rise_pulse !== exp_rise || fall_pulse !== exp_fall) begin
        errors++;
        $display("FAIL glitch5 step=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=%b",
                 i, level_out, rise_pulse, fall_pulse, exp_lvl, exp_rise, exp_fall);
      end
    end
  endtask

  task automatic test_independence();
    raw_in = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 2) raw_in = 2'b11;
      exp_lvl  = {(i >= 9) ? 1'b1 : 1'b0, (i >= 7) ? 1'b1 : 1'b0};
      exp_rise = {(i == 9) ? 1'b1 : 1'b0, (i == 7) ? 1'b1 : 1'b0};
      exp_x    = (i == 7 || i == 8);
      checks++;
      if (level_out !== exp_lvl || rise_pulse !== exp_rise || fall_pulse !== 2'b00 ||
          (level_out[0] ^ level_out[1]) !== exp_x) begin
        errors++;
        $display("FAIL indep step=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=00 xor=%b",
                 i, level_out, rise_pulse, fall_pulse, exp_lvl, exp_rise, exp_x);
      end
    end
    raw_in = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_lvl  = (i >= 7) ? 2'b00 : 2'b11;
      exp_fall = (i == 7) ? 2'b11 : 2'b00;
      checks++;
      if (level_out !== exp_lvl || fall_pulse !== exp_fall || rise_pulse !== 2'b00) begin
        errors++;
        $display("FAIL simul_fall step=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=00 fall=%b",
                 i, level_out, rise_pulse, fall_pulse, exp_lvl, exp_fall);
      end
    end
  endtask

  task automatic test_reset_mid();
    raw_in = 2'b01;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if (level_out !== 2'b00 || rise_pulse !== 2'b00) begin
        errors++;
        $display("FAIL mid_pre step=%0d got lvl=%b rise=%b exp lvl=00 rise=00", i, level_out, rise_pulse);
      end
    end
    // counter now at 4 in WAIT_HIGH; one more high cycle would accept
    rst_n = 1'b0;
    #2;
    checks++;
    if ({level_out, rise_pulse, fall_pulse} !== 6'b0) begin
      errors++;
      $display("FAIL mid_async got lvl=%b rise=%b fall=%b exp all 0", level_out, rise_pulse, fall_pulse);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({level_out, rise_pulse, fall_pulse} !== 6'b0) begin
        errors++;
        $display("FAIL mid_hold cyc=%0d got lvl=%b rise=%b fall=%b exp all 0", i, level_out, rise_pulse, fall_pulse);
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_lvl  = (i >= 7) ? 2'b01 : 2'b00;
      exp_rise = (i == 7) ? 2'b01 : 2'b00;
      checks++;
      if (level_out !== exp_lvl || rise_pulse !== exp_rise || fall_pulse !== 2'b00) begin
        errors++;
        $display("FAIL mid_release step=%0d got lvl=%b rise=%b fall=%b exp lvl=%b rise=%b fall=00",
                 i, level_out, rise_pulse, fall_pulse, exp_lvl, exp_rise);
      end
    end
    raw_in = 2'b00;
    repeat (8) step();
    checks++;
    if (level_out !== 2'b00) begin
      errors++;
      $display("FAIL mid_cleanup got lvl=%b exp 00", level_out);
    end
  endtask

  task automatic test_long_hold();
    n_rise0 = 0; n_rise1 = 0; n_fall0 = 0; n_fall1 = 0;
    raw_in = 2'b01;
    for (int i = 0; i < 100; i++) begin
      step();
      n_rise0 += int'(rise_pulse[0]);
      n_rise1 += int'(rise_pulse[1]);
      n_fall0 += int'(fall_pulse[0]);
      n_fall1 += int'(fall_pulse[1]);
    end
    checks++;
    if (n_rise0 != 1) begin
      errors++;
      $display("FAIL hold_rise0 got count=%0d exp 1", n_rise0);
    end
    checks++;
    if (n_rise1 != 0 || n_fall1 != 0) begin
      errors++;
      $display("FAIL hold_ch1 got rise=%0d fall=%0d exp 0 0", n_rise1, n_fall1);
    end
    checks++;
    if (n_fall0 != 0) begin
      errors++;
      $display("FAIL hold_fall0 got count=%0d exp 0", n_fall0);
    end
    checks++;
    if (level_out !== 2'b01) begin
      errors++;
      $display("FAIL hold_level got lvl=%b exp 01", level_out);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    raw_in = 2'b00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_independence();
    test_reset_mid();
    test_long_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Per-channel synchronizer and debouncer for raw board switches/pushbuttons. Each channel produces a clean, glitch-free level and single-cycle edge pulses. The block sits directly upstream of `my_xor`: `level_out[0]` drives `a` and `level_out[1]` drives `b`. Channels are independent and share one clock and reset.

## Interface
- `WIDTH`, 2: number of independent input channels (≥1).
- `SYNC_STAGES`, 2: synchronizer flip-flop depth (≥2).
- `CNT_MAX`, 500000: consecutive stable cycles required to accept a new level (≥1); 10 ms at 50 MHz.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous and active-low.
- `raw_in`  input  WIDTH  asynchronous raw switch/button levels, active-high after board inversion.
- `level_out`  output  WIDTH  debounced level per channel; bits 0/1 feed `my_xor` `a`/`b`.
- `rise_pulse`  output  WIDTH  one-cycle pulse when `level_out[i]` goes 0→1.
- `fall_pulse`  output  WIDTH  one-cycle pulse when `level_out[i]` goes 1→0.

## Operation
- Reset (`rst_n`=0, asynchronous): all synchronizer flops, counters, FSMs, `level_out`, `rise_pulse` and `fall_pulse` go to 0 immediately. States go to STABLE_LOW.
- Synchronizer: `raw_in[i]` passes through SYNC_STAGES flops. `s[i]` is the last stage. Nothing downstream uses `raw_in` directly.
- Per-channel FSM, 4 states:
  - STABLE_LOW: `level`=0. If `s`=1, go to WAIT_HIGH and set `cnt`=1.
  - WAIT_HIGH: if `s`=0, go to STABLE_LOW and set `cnt`=0 (bounce rejected). If `s`=1 and `cnt`==CNT_MAX, go to STABLE_HIGH, set `level`=1 and `cnt`=0. Otherwise increment `cnt`.
  - STABLE_HIGH and WAIT_LOW: mirror images of the two states above, with polarity reversed.
- With CNT_MAX=1, WAIT_x accepts on its first cycle if `s` is unchanged.
- Counter width is $clog2(CNT_MAX+1). `cnt` never exceeds CNT_MAX and never wraps.
- `rise_pulse[i]`/`fall_pulse[i]` are registered. Each is high for exactly the one cycle after the edge on which `level_out[i]` changes (i.e. pulse high ⇔ `level_out` differs from its previous-cycle value).
- At most one pulse per change. A held input never re-pulses.
- `rise_pulse[i]` and `fall_pulse[i]` are never high together.
- Channels are fully independent. Simultaneous changes on several channels each debounce and pulse in the same cycle.

## Timing
- A raw change, stable from before edge 0, appears at `s` after edge SYNC_STAGES-1. WAIT starts on edge SYNC_STAGES.
- `level_out` changes on edge SYNC_STAGES+CNT_MAX. Total latency is SYNC_STAGES+CNT_MAX cycles.
- The matching pulse is high during the cycle that follows that edge, and clears on the next edge.
- A glitch on `s` shorter than CNT_MAX+1 cycles produces no change on `level_out` and no pulse.
- A glitch that returns mid-WAIT restarts the full count on the next departure.
- Reset asserted mid-count: everything clears asynchronously and no pulse is emitted. After release, a held-high input needs the full SYNC_STAGES+CNT_MAX latency and then produces one `rise_pulse`.
- Reset deassertion is assumed synchronized externally. The first state update occurs on the first rising edge with `rst_n`=1.

## Test plan
Bench uses WIDTH=2, SYNC_STAGES=2, CNT_MAX=4, and a 10 ns clock.
1. Reset check: hold `rst_n`=0 with `raw_in`=2'b11 for 50 ns → all outputs 0 throughout. Release → `level_out`=2'b11 exactly 6 cycles after the first active edge, with `rise_pulse`=2'b11 for one cycle.
2. Clean press: `raw_in[0]` 0→1 and held → `level_out[0]`=1 after 6 cycles, one `rise_pulse[0]`, `my_xor` output=1. Release → `level_out[0]`=0 after 6 cycles, one `fall_pulse[0]`.
3. Bounce rejection: `raw_in[0]` toggles 1,0,1,0 every 20 ns, then stays 0 → `level_out[0]` stays 0 and no pulses occur. A 1-pulse of exactly 4 stable `s` cycles → no change; 5 cycles → change.
4. Independence: `raw_in[1]` goes high 2 cycles after `raw_in[0]` → `level_out[1]` changes exactly 2 cycles after `level_out[0]`. `my_xor` out sequence is 1 then 0.
5. Reset mid-count: `raw_in[0]`=1, then assert `rst_n`=0 at cycle 4 of WAIT_HIGH → immediate clear with no pulse. After release, a full 6-cycle latency then one `rise_pulse[0]`.
6. Long hold: `raw_in`=2'b01 held for 100 cycles → exactly one `rise_pulse[0]` and zero pulses on channel 1.
